// File: rtl/mips_pkg.sv
// Shared encodings for the lab MIPS execute core: opcodes, R-type functs,
// GPIO CSR addresses and the ALU / writeback-select enums.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_GPIO  = 6'h1F;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [15:0] GPIO_RD_CSR = 16'hF00;
  localparam logic [15:0] GPIO_WR_CSR = 16'hF02;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_NOR   = 4'd3,
    ALU_ADD   = 4'd4,
    ALU_SUB   = 4'd5,
    ALU_MULT  = 4'd6,
    ALU_MULTU = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_SLL   = 4'd10,
    ALU_SRL   = 4'd11,
    ALU_SRA   = 4'd12,
    ALU_LUI   = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_HI   = 2'd1,
    WB_LO   = 2'd2,
    WB_GPIO = 2'd3
  } wb_sel_e;
endpackage

// File: rtl/mips_alu.sv
// Combinational ALU; hi_o is only non-zero for the two multiply ops.
module mips_alu
  import mips_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;

  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'b0, a_i} * {32'b0, b_i};

  always_comb begin
    lo_o = '0;
    hi_o = '0;
    unique case (op_i)
      ALU_AND:   lo_o = a_i & b_i;
      ALU_OR:    lo_o = a_i | b_i;
      ALU_XOR:   lo_o = a_i ^ b_i;
      ALU_NOR:   lo_o = ~(a_i | b_i);
      ALU_ADD:   lo_o = a_i + b_i;
      ALU_SUB:   lo_o = a_i - b_i;
      ALU_MULT:  {hi_o, lo_o} = prod_s;
      ALU_MULTU: {hi_o, lo_o} = prod_u;
      ALU_SLT:   lo_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  lo_o = {31'b0, a_i < b_i};
      ALU_SLL:   lo_o = b_i << shamt_i;
      ALU_SRL:   lo_o = b_i >> shamt_i;
      ALU_SRA:   lo_o = $signed(b_i) >>> shamt_i;
      ALU_LUI:   lo_o = {b_i[15:0], 16'b0};
      default:   lo_o = '0;
    endcase
  end
endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports with write-through
// bypass, one synchronous write port, $0 hard-wired to zero.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);
  logic [31:0] regs_q [32];
  logic        wr_live;

  assign wr_live = we_i && (waddr_i != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // The word committing this cycle is forwarded so the next instruction sees it.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
    if (wr_live && raddr_a_i == waddr_i) rdata_a_o = wdata_i;
    if (wr_live && raddr_b_i == waddr_i) rdata_b_o = wdata_i;
    if (raddr_a_i == 5'd0) rdata_a_o = '0;
    if (raddr_b_i == 5'd0) rdata_b_o = '0;
  end
endmodule

// File: rtl/mips_exec_core.sv
// Decode/execute/writeback core: decodes the EX instruction, runs the ALU,
// registers the writeback and owns HI/LO and the GPIO output word.
module mips_exec_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_EX,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        zero_EX
);
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign op    = instruction_EX[31:26];
  assign rs    = instruction_EX[25:21];
  assign rt    = instruction_EX[20:16];
  assign rd    = instruction_EX[15:11];
  assign shamt = instruction_EX[10:6];
  assign funct = instruction_EX[5:0];
  assign imm   = instruction_EX[15:0];

  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        use_imm, imm_sext, reg_write_d, hilo_write, gpio_write;
  logic [4:0]  dest_d;

  always_comb begin
    alu_op      = ALU_ADD;
    wb_sel      = WB_ALU;
    use_imm     = 1'b0;
    imm_sext    = 1'b0;
    reg_write_d = 1'b0;
    hilo_write  = 1'b0;
    gpio_write  = 1'b0;
    dest_d      = rd;
    unique case (op)
      OP_RTYPE: begin
        reg_write_d = 1'b1;
        unique case (funct)
          FN_SLL:           alu_op = ALU_SLL;
          FN_SRL:           alu_op = ALU_SRL;
          FN_SRA:           alu_op = ALU_SRA;
          FN_MFHI:          wb_sel = WB_HI;
          FN_MFLO:          wb_sel = WB_LO;
          FN_MULT:  begin alu_op = ALU_MULT;  reg_write_d = 1'b0; hilo_write = 1'b1; end
          FN_MULTU: begin alu_op = ALU_MULTU; reg_write_d = 1'b0; hilo_write = 1'b1; end
          FN_ADD, FN_ADDU:  alu_op = ALU_ADD;
          FN_SUB, FN_SUBU:  alu_op = ALU_SUB;
          FN_AND:           alu_op = ALU_AND;
          FN_OR:            alu_op = ALU_OR;
          FN_XOR:           alu_op = ALU_XOR;
          FN_NOR:           alu_op = ALU_NOR;
          FN_SLT:           alu_op = ALU_SLT;
          FN_SLTU:          alu_op = ALU_SLTU;
          default:          reg_write_d = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        use_imm     = 1'b1;
        imm_sext    = 1'b1;
        reg_write_d = 1'b1;
        dest_d      = rt;
        alu_op      = (op == OP_SLTI)  ? ALU_SLT  :
                      (op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        use_imm     = 1'b1;
        reg_write_d = 1'b1;
        dest_d      = rt;
        alu_op      = (op == OP_ANDI) ? ALU_AND :
                      (op == OP_ORI)  ? ALU_OR  :
                      (op == OP_XORI) ? ALU_XOR : ALU_LUI;
      end
      OP_GPIO: begin
        dest_d = rt;
        if (imm == GPIO_RD_CSR) begin
          wb_sel      = WB_GPIO;
          reg_write_d = 1'b1;
        end else if (imm == GPIO_WR_CSR) begin
          gpio_write  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  logic        regwrite_WB_q;
  logic [4:0]  writeaddr_WB_q;
  logic [31:0] writedata_WB_q, writedata_d;
  logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_lo, alu_hi;
  logic [31:0] hi_q, lo_q, gpio_out_q;

  mips_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val),
    .we_i      (regwrite_WB_q),
    .waddr_i   (writeaddr_WB_q),
    .wdata_i   (writedata_WB_q)
  );

  assign imm_ext = imm_sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
  assign alu_b   = use_imm ? imm_ext : rt_val;

  mips_alu u_alu (
    .op_i    (alu_op),
    .a_i     (rs_val),
    .b_i     (alu_b),
    .shamt_i (shamt),
    .lo_o    (alu_lo),
    .hi_o    (alu_hi)
  );

  assign zero_EX = (alu_lo == 32'd0);

  always_comb begin
    unique case (wb_sel)
      WB_HI:   writedata_d = hi_q;
      WB_LO:   writedata_d = lo_q;
      WB_GPIO: writedata_d = gpio_in;
      default: writedata_d = alu_lo;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_WB_q  <= 1'b0;
      writeaddr_WB_q <= '0;
      writedata_WB_q <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      gpio_out_q     <= '0;
    end else begin
      regwrite_WB_q  <= reg_write_d;
      writeaddr_WB_q <= dest_d;
      writedata_WB_q <= writedata_d;
      if (hilo_write) begin
        hi_q <= alu_hi;
        lo_q <= alu_lo;
      end
      if (gpio_write) gpio_out_q <= rt_val;
    end
  end

  assign gpio_out = gpio_out_q;
endmodule

// File: tb/tb_mips_exec_core.sv
// Bench for mips_exec_core: directed scenarios plus random instruction
// streams compared against an architectural (one-instruction-at-a-time) model.
module tb_mips_exec_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction_EX;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        zero_EX;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo, m_gpio;

  mips_exec_core dut (
    .clk            (clk),
    .rst            (rst),
    .instruction_EX (instruction_EX),
    .gpio_in        (gpio_in),
    .gpio_out       (gpio_out),
    .zero_EX        (zero_EX)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, want %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs_f,
                                        input logic [4:0] rt_f, input logic [4:0] rd_f,
                                        input logic [4:0] sh);
    return {6'h00, rs_f, rt_f, rd_f, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs_f,
                                        input logic [4:0] rt_f, input logic [15:0] im);
    return {opc, rs_f, rt_f, im};
  endfunction

  function automatic logic [31:0] gpio_wr(input logic [4:0] r);
    return enc_i(6'h1F, 5'd0, r, 16'hF02);
  endfunction

  function automatic logic [31:0] gpio_rd(input logic [4:0] r);
    return enc_i(6'h1F, 5'd0, r, 16'hF00);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_hi = '0;
    m_lo = '0;
    m_gpio = '0;
  endtask

  // Architectural effect of one instruction; zv says whether zero_EX is defined.
  task automatic model_step(input logic [31:0] ins, input logic [31:0] gin,
                            output bit zv, output logic [31:0] alu_res);
    logic [5:0]  op, fn;
    logic [4:0]  rs_f, rt_f, rd_f, sh, d;
    logic [15:0] im;
    logic [31:0] a, b, simm, zimm, res;
    logic [63:0] p;
    longint      ps;
    bit          wr;
    op = ins[31:26]; rs_f = ins[25:21]; rt_f = ins[20:16]; rd_f = ins[15:11];
    sh = ins[10:6]; fn = ins[5:0]; im = ins[15:0];
    a = m_regs[rs_f]; b = m_regs[rt_f];
    simm = {{16{im[15]}}, im};
    zimm = {16'h0, im};
    res = '0; wr = 0; zv = 0; d = rd_f;
    if (op == 6'h00) begin
      wr = 1; zv = 1;
      case (fn)
        6'h00: res = b << sh;
        6'h02: res = b >> sh;
        6'h03: res = int'(b) >>> sh;
        6'h10: begin res = m_hi; zv = 0; end
        6'h12: begin res = m_lo; zv = 0; end
        6'h18: begin
          ps = longint'(int'(a)) * longint'(int'(b));
          p = 64'(ps);
          m_hi = p[63:32]; m_lo = p[31:0]; res = p[31:0]; wr = 0;
        end
        6'h19: begin
          p = 64'(a) * 64'(b);
          m_hi = p[63:32]; m_lo = p[31:0]; res = p[31:0]; wr = 0;
        end
        6'h20, 6'h21: res = a + b;
        6'h22, 6'h23: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        6'h2B: res = (a < b) ? 32'd1 : 32'd0;
        default: begin wr = 0; zv = 0; end
      endcase
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      wr = 1; zv = 1; d = rt_f;
      case (op)
        6'h08, 6'h09: res = a + simm;
        6'h0A: res = (int'(a) < int'(simm)) ? 32'd1 : 32'd0;
        6'h0B: res = (a < simm) ? 32'd1 : 32'd0;
        6'h0C: res = a & zimm;
        6'h0D: res = a | zimm;
        6'h0E: res = a ^ zimm;
        default: res = zimm << 16;
      endcase
    end else if (op == 6'h1F && im == 16'hF00) begin
      wr = 1; d = rt_f; res = gin;
    end else if (op == 6'h1F && im == 16'hF02) begin
      m_gpio = b;
    end
    if (wr && d != 5'd0) m_regs[d] = res;
    alu_res = res;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic run(input logic [31:0] ins, input logic [31:0] gin);
    bit          zv;
    logic [31:0] r;
    instruction_EX = ins;
    gpio_in = gin;
    #1;
    model_step(ins, gin, zv, r);
    if (zv) check("zero_EX", {31'b0, zero_EX}, {31'b0, r == 32'd0});
    @(negedge clk);
    check("gpio_out", gpio_out, m_gpio);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instruction_EX = '0;
    #1;
    check("rst_gpio_async", gpio_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [5:0] r_fns [17] = '{6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h19, 6'h20, 6'h21,
                             6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] bad_fns [3] = '{6'h01, 6'h11, 6'h3F};

  initial begin
    logic [31:0] ins;
    int          sel;
    rst = 1'b1;
    instruction_EX = '0;
    gpio_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_gpio", gpio_out, 32'h0);

    run(enc_i(6'h08, 0, 1, 16'd5), 0);
    run(gpio_wr(1), 0);
    check("tp_addi5", gpio_out, 32'h5);

    run(enc_i(6'h08, 0, 1, 16'hFFFF), 0);
    run(enc_r(6'h21, 1, 1, 2, 0), 0);
    run(gpio_wr(2), 0);
    check("tp_bypass", gpio_out, 32'hFFFFFFFE);

    run(enc_i(6'h0F, 0, 3, 16'd1), 0);
    run(enc_r(6'h18, 3, 3, 0, 0), 0);
    run(enc_r(6'h10, 0, 0, 4, 0), 0);
    run(enc_r(6'h12, 0, 0, 5, 0), 0);
    run(gpio_wr(4), 0);
    check("tp_mult_hi", gpio_out, 32'h1);
    run(gpio_wr(5), 0);
    check("tp_mult_lo", gpio_out, 32'h0);

    run(enc_i(6'h08, 0, 7, 16'hFFFF), 0);
    run(enc_r(6'h19, 7, 7, 0, 0), 0);
    run(enc_r(6'h10, 0, 0, 4, 0), 0);
    run(enc_r(6'h12, 0, 0, 5, 0), 0);
    run(gpio_wr(4), 0);
    check("tp_multu_hi", gpio_out, 32'hFFFFFFFE);
    run(gpio_wr(5), 0);
    check("tp_multu_lo", gpio_out, 32'h1);

    run(gpio_rd(6), 32'hA5A5A5A5);
    run(gpio_wr(6), 32'h0);
    check("tp_gpio_rd", gpio_out, 32'hA5A5A5A5);
    run(enc_i(6'h08, 0, 0, 16'd7), 0);
    run(gpio_wr(0), 0);
    check("tp_r0", gpio_out, 32'h0);

    run(enc_i(6'h08, 0, 1, 16'hFFFF), 0);
    run(enc_i(6'h08, 0, 2, 16'd1), 0);
    run(enc_r(6'h2A, 1, 2, 8, 0), 0);
    run(gpio_wr(8), 0);
    check("tp_slt", gpio_out, 32'h1);
    run(enc_r(6'h2B, 1, 2, 8, 0), 0);
    run(gpio_wr(8), 0);
    check("tp_sltu", gpio_out, 32'h0);
    run(enc_i(6'h0F, 0, 3, 16'h8000), 0);
    run(enc_r(6'h03, 0, 3, 9, 5'd4), 0);
    run(gpio_wr(9), 0);
    check("tp_sra", gpio_out, 32'hF8000000);
    run(enc_i(6'h3E, 0, 9, 16'h1234), 0);
    run(gpio_wr(9), 0);
    check("tp_illegal", gpio_out, 32'hF8000000);

    run(enc_r(6'h18, 3, 3, 0, 0), 0);
    do_reset();
    run(enc_r(6'h10, 0, 0, 4, 0), 0);
    run(gpio_wr(4), 0);
    check("tp_rst_hi", gpio_out, 32'h0);
    run(enc_r(6'h12, 0, 0, 5, 0), 0);
    run(gpio_wr(5), 0);
    check("tp_rst_lo", gpio_out, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 2) begin
        ins = gpio_wr(5'($urandom_range(0, 7)));
      end else if (sel == 3) begin
        ins = gpio_rd(5'($urandom_range(0, 7)));
      end else if (sel == 4) begin
        case ($urandom_range(0, 2))
          0: ins = enc_i(6'h3E, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
          1: ins = enc_i(6'h1F, 0, 5'($urandom_range(0, 7)), 16'hF01);
          default: ins = enc_r(bad_fns[$urandom_range(0, 2)], 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
        endcase
      end else if (sel <= 7) begin
        ins = enc_r(r_fns[$urandom_range(0, 16)], 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
      end else begin
        ins = enc_i(6'($urandom_range(8, 15)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 16'($urandom));
      end
      run(ins, $urandom);
      if (n == 750) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
